// File: rtl/readout_stream_decoder.sv
// readout_stream_decoder
// Unpacks the zero-compressed 32-bit readout stream (timestamp LSB/MSB
// headers, ETROC1/ETROC2 TDC words, fillers) into one record per hit, with
// the reconstructed 52-bit timestamp, on a valid/ready output. Malformed
// words are counted in saturating status counters.
module readout_stream_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk160,
  input  logic             reset_n,
  input  logic             noTimestamp,
  input  logic [31:0]      in_data,
  input  logic             in_empty,
  output logic             in_rd_en,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [1:0]       hit_channel,
  output logic             hit_etroc2,
  output logic [28:0]      hit_tdc,
  output logic [51:0]      hit_timestamp,
  output logic             hit_random,
  output logic             hit_first,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] filler_count,
  output logic [CNT_W-1:0] error_count
);

  localparam logic [31:0] FILLER_WORD = 32'h0000_9800;

  typedef enum logic [1:0] {IDLE, HDR, HITS} state_t;
  typedef enum logic [2:0] {W_FILLER, W_LSB, W_MSB, W_TDC, W_BAD} kind_t;

  state_t      state;
  logic [25:0] lsb;
  logic [25:0] msb;
  logic        random_q;
  logic        have_prev;   // a hit has already been seen in this event
  logic [1:0]  prev_ch;

  kind_t       kind;
  logic [1:0]  w_ch;
  logic [28:0] w_tdc;
  logic        w_etroc2;

  logic        pop;
  logic        tdc_pop;
  logic        order_err;
  logic        err_inc;
  logic        evt_inc;
  logic        fil_inc;

  // The output register can take a new word whenever it is empty or being
  // drained this cycle; nothing is popped while reset is held.
  assign in_rd_en = reset_n & ~in_empty & (~hit_valid | hit_ready);
  assign pop      = in_rd_en;

  // Classify the word at the FIFO head and extract the hit fields.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    kind     = W_BAD;
    w_ch     = 2'd0;
    w_tdc    = 29'd0;
    w_etroc2 = 1'b0;
    if (noTimestamp) begin
      if (in_data == 32'h0) begin
        kind = W_FILLER;
      end else if (in_data[0]) begin
        kind  = W_TDC;
        w_ch  = in_data[31:30];
        w_tdc = in_data[29:1];
      end
    end else if (in_data == FILLER_WORD) begin
      kind = W_FILLER;
    end else if (in_data[31:27] == 5'b10000) begin
      kind = W_LSB;
    end else if (in_data[31:26] == 6'b100011) begin
      kind = W_MSB;
    end else if (in_data[31:30] == 2'b11) begin
      kind     = W_TDC;
      w_ch     = in_data[29:28];
      w_tdc    = {1'b0, in_data[27:0]};
      w_etroc2 = 1'b1;
    end else if (!in_data[31]) begin
      kind  = W_TDC;
      w_ch  = in_data[30:29];
      w_tdc = in_data[28:0];
    end
  end

  assign tdc_pop   = pop & (kind == W_TDC);
  assign order_err = ~noTimestamp & have_prev & (w_ch <= prev_ch);

  // One error increment per word, however many rules the word breaks.
  assign err_inc = pop & ((kind == W_BAD)
                        | ((kind == W_MSB) & (state != HDR))
                        | ((kind == W_TDC) & ~noTimestamp & ((state == IDLE) | order_err)));
  assign evt_inc = pop & (noTimestamp ? (kind == W_TDC) : (kind == W_LSB));
  assign fil_inc = pop & (kind == W_FILLER);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic en);
    return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  endfunction

  // Header tracking, event state machine and the output hit record.
  always_ff @(posedge clk160 or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state         <= IDLE;
      lsb           <= '0;
      msb           <= '0;
      random_q      <= 1'b0;
      have_prev     <= 1'b0;
      prev_ch       <= 2'd0;
      hit_valid     <= 1'b0;
      hit_channel   <= 2'd0;
      hit_etroc2    <= 1'b0;
      hit_tdc       <= '0;
      hit_timestamp <= '0;
      hit_random    <= 1'b0;
      hit_first     <= 1'b0;
    end else begin
      if (tdc_pop) begin
        hit_valid     <= 1'b1;
        hit_channel   <= w_ch;
        hit_etroc2    <= w_etroc2;
        hit_tdc       <= w_tdc;
        hit_timestamp <= noTimestamp ? 52'd0 : {msb, lsb};
        hit_random    <= random_q;
        hit_first     <= ~noTimestamp & (state != IDLE) & ~have_prev;
      end else if (hit_ready) begin
        hit_valid <= 1'b0;
      end

      if (pop && !noTimestamp) begin
        case (kind)
          W_LSB: begin
            lsb       <= in_data[25:0];
            random_q  <= in_data[26];
            have_prev <= 1'b0;
            state     <= HDR;
          end
          W_MSB: begin
            if (state == HDR) begin
              msb   <= in_data[25:0];
              state <= HITS;
            end
          end
          W_TDC: begin
            have_prev <= 1'b1;
            prev_ch   <= w_ch;
            if (state != IDLE) state <= HITS;
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating status counters.
  always_ff @(posedge clk160 or negedge reset_n) begin
    if (!reset_n) begin
      event_count  <= '0;
      filler_count <= '0;
      error_count  <= '0;
    end else begin
      event_count  <= sat_inc(event_count, evt_inc);
      filler_count <= sat_inc(filler_count, fil_inc);
      error_count  <= sat_inc(error_count, err_inc);
    end
  end

endmodule

// File: tb/tb_readout_stream_decoder.sv
// tb_readout_stream_decoder
// Self-checking bench: a table of single-word steps from reset, hand-written
// sequences for orphans, back-pressure, noTimestamp mode and mid-stream
// reset, a randomized stream compared against a word-level reference model,
// and a long filler run for counter saturation.
module tb_readout_stream_decoder;

  typedef struct packed {
    logic [1:0]  ch;
    logic        e2;
    logic [28:0] tdc;
    logic [51:0] ts;
    logic        rnd;
    logic        first;
  } rec_t;

  typedef struct {
    logic [31:0] word;
    logic        v;
    rec_t        r;
    logic [15:0] evt;
    logic [15:0] fil;
    logic [15:0] err;
  } vec_t;

  logic        clk160;
  logic        reset_n;
  logic        noTimestamp;
  logic [31:0] in_data;
  logic        in_empty;
  logic        in_rd_en;
  logic        hit_valid;
  logic        hit_ready;
  logic [1:0]  hit_channel;
  logic        hit_etroc2;
  logic [28:0] hit_tdc;
  logic [51:0] hit_timestamp;
  logic        hit_random;
  logic        hit_first;
  logic [15:0] event_count;
  logic [15:0] filler_count;
  logic [15:0] error_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] src_q[$];
  rec_t        exp_q[$];
  logic [15:0] exp_evt, exp_fil, exp_err;

  vec_t tbl[21];

  readout_stream_decoder #(.CNT_W(16)) dut (
    .clk160        (clk160),
    .reset_n       (reset_n),
    .noTimestamp   (noTimestamp),
    .in_data       (in_data),
    .in_empty      (in_empty),
    .in_rd_en      (in_rd_en),
    .hit_valid     (hit_valid),
    .hit_ready     (hit_ready),
    .hit_channel   (hit_channel),
    .hit_etroc2    (hit_etroc2),
    .hit_tdc       (hit_tdc),
    .hit_timestamp (hit_timestamp),
    .hit_random    (hit_random),
    .hit_first     (hit_first),
    .event_count   (event_count),
    .filler_count  (filler_count),
    .error_count   (error_count)
  );

  initial clk160 = 1'b0;
  always #5 clk160 = ~clk160;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rec_t mkrec(input int ch, input bit e2, input logic [28:0] tdc,
                                 input logic [25:0] m, input logic [25:0] l,
                                 input bit rnd, input bit first);
    rec_t r;
    r.ch = 2'(ch); r.e2 = e2; r.tdc = tdc; r.ts = {m, l}; r.rnd = rnd; r.first = first;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [31:0] w, input bit v, input rec_t r,
                               input int evt, input int fil, input int err);
    vec_t t;
    t.word = w; t.v = v; t.r = r; t.evt = 16'(evt); t.fil = 16'(fil); t.err = 16'(err);
    return t;
  endfunction

  function automatic rec_t cur_rec();
    return {hit_channel, hit_etroc2, hit_tdc, hit_timestamp, hit_random, hit_first};
  endfunction

  function automatic logic [15:0] sat16(input int x);
    return (x > 65535) ? 16'hFFFF : 16'(x);
  endfunction

  // Word-level reference: walks the whole stream in order and lists the
  // hits it must produce plus the final counter values. Back-pressure and
  // FIFO gaps do not change either, since no word is ever dropped.
  function automatic void model_stream();
    bit          in_event = 1'b0;
    bit          hdr_open = 1'b0;
    int          last_ch  = -1;
    int          evt = 0, fil = 0, err = 0, ch;
    logic [25:0] m_lsb = '0, m_msb = '0;
    logic        m_rnd = 1'b0;
    logic [31:0] w;
    rec_t        r;
    exp_q.delete();
    foreach (src_q[i]) begin
      w = src_q[i];
      if (w == 32'h0000_9800) begin
        fil++;
      end else if (w[31:27] == 5'b10000) begin
        m_lsb = w[25:0]; m_rnd = w[26]; evt++;
        in_event = 1'b1; hdr_open = 1'b1; last_ch = -1;
      end else if (w[31:26] == 6'b100011) begin
        if (hdr_open) begin m_msb = w[25:0]; hdr_open = 1'b0; end
        else err++;
      end else if (w[31:30] == 2'b11 || !w[31]) begin
        if (w[31]) begin ch = int'(w[29:28]); r.tdc = {1'b0, w[27:0]}; r.e2 = 1'b1; end
        else begin ch = int'(w[30:29]); r.tdc = w[28:0]; r.e2 = 1'b0; end
        r.ch = 2'(ch); r.ts = {m_msb, m_lsb}; r.rnd = m_rnd;
        r.first = in_event && (last_ch < 0);
        if (!in_event || ch <= last_ch) err++;
        last_ch = ch; hdr_open = 1'b0;
        exp_q.push_back(r);
      end else begin
        err++;
      end
    end
    exp_evt = sat16(evt); exp_fil = sat16(fil); exp_err = sat16(err);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r = $urandom;
    case ($urandom_range(9))
      0:       return 32'h0000_9800;
      1, 2:    return {5'b10000, r[26:0]};
      3:       return {6'b100011, r[25:0]};
      4, 5, 6: return {1'b0, r[30:0]};
      7:       return {2'b11, r[29:0]};
      8:       return {3'b101, r[28:0]};
      default: return {6'b100010, r[25:0]};
    endcase
  endfunction

  task automatic do_reset(input bit nots);
    reset_n = 1'b0; in_empty = 1'b1; in_data = '0; hit_ready = 1'b1; noTimestamp = nots;
    repeat (2) @(posedge clk160);
    #1 reset_n = 1'b1;
  endtask

  // Present one word with the consumer ready and let it be popped.
  task automatic apply_word(input logic [31:0] w);
    in_data = w; in_empty = 1'b0; #1;
    check("rd_en", in_rd_en, 1'b1);
    @(posedge clk160); #1;
    in_empty = 1'b1;
  endtask

  task automatic feed_cycle(output bit popped);
    in_empty = (src_q.size() == 0);
    in_data  = in_empty ? 32'h0 : src_q[0];
    #1;
    popped = in_rd_en;
    @(posedge clk160); #1;
    if (popped) void'(src_q.pop_front());
    in_empty = 1'b1;
  endtask

  // Streams src_q through the DUT and scores every accepted hit.
  task automatic run_stream(input bit gaps, input int budget);
    int   cyc = 0;
    bit   popped, acc;
    rec_t got;
    model_stream();
    while ((src_q.size() != 0 || hit_valid) && cyc < budget) begin
      in_empty  = (src_q.size() == 0) || (gaps && $urandom_range(3) == 0);
      in_data   = in_empty ? $urandom : src_q[0];
      hit_ready = gaps ? ($urandom_range(2) != 0) : 1'b1;
      #1;
      popped = in_rd_en;
      acc    = hit_valid & hit_ready;
      got    = cur_rec();
      @(posedge clk160); #1;
      if (popped) void'(src_q.pop_front());
      if (acc) begin
        if (exp_q.size() == 0) check("extra_hit", got, '0);
        else check("stream_hit", got, exp_q.pop_front());
      end
      cyc++;
    end
    in_empty = 1'b1; hit_ready = 1'b1;
    check("stream_done", cyc < budget, 1'b1);
    check("stream_missing_hits", exp_q.size(), 0);
    check("stream_counters", {event_count, filler_count, error_count}, {exp_evt, exp_fil, exp_err});
  endtask

  initial begin
    bit p;
    int pops;
    rec_t held;

    tbl[0]  = mkv(32'h0000_9800, 0, '0, 0, 1, 0);
    tbl[1]  = mkv(32'h8400_0005, 0, '0, 1, 1, 0);
    tbl[2]  = mkv(32'h8C00_0003, 0, '0, 1, 1, 0);
    tbl[3]  = mkv(32'h0000_1234, 1, mkrec(0, 0, 29'h1234, 3, 5, 1, 1), 1, 1, 0);
    tbl[4]  = mkv(32'hD000_0ABC, 1, mkrec(1, 1, 29'hABC, 3, 5, 1, 0), 1, 1, 0);
    tbl[5]  = mkv(32'h0000_9800, 0, '0, 1, 2, 0);
    tbl[6]  = mkv(32'h8000_0009, 0, '0, 2, 2, 0);
    tbl[7]  = mkv(32'h4000_0077, 1, mkrec(2, 0, 29'h77, 3, 9, 0, 1), 2, 2, 0);
    tbl[8]  = mkv(32'h8C00_0004, 0, '0, 2, 2, 1);
    tbl[9]  = mkv(32'h2000_0001, 1, mkrec(1, 0, 29'h1, 3, 9, 0, 0), 2, 2, 2);
    tbl[10] = mkv(32'hA000_0000, 0, '0, 2, 2, 3);
    tbl[11] = mkv(32'h8800_0000, 0, '0, 2, 2, 4);
    tbl[12] = mkv(32'h8000_0010, 0, '0, 3, 2, 4);
    tbl[13] = mkv(32'hF123_4567, 1, mkrec(3, 1, 29'h0123_4567, 3, 'h10, 0, 1), 3, 2, 4);
    tbl[14] = mkv(32'h8C00_00FF, 0, '0, 3, 2, 5);
    tbl[15] = mkv(32'h8400_0001, 0, '0, 4, 2, 5);
    tbl[16] = mkv(32'h8400_0002, 0, '0, 5, 2, 5);
    tbl[17] = mkv(32'h8C00_0007, 0, '0, 5, 2, 5);
    tbl[18] = mkv(32'h6000_0005, 1, mkrec(3, 0, 29'h5, 7, 2, 1, 1), 5, 2, 5);
    tbl[19] = mkv(32'h7FFF_FFFF, 1, mkrec(3, 0, 29'h1FFF_FFFF, 7, 2, 1, 0), 5, 2, 6);
    tbl[20] = mkv(32'h0000_9800, 0, '0, 5, 3, 6);

    // Reset state, with a word waiting in the FIFO.
    reset_n = 1'b0; noTimestamp = 1'b0; in_data = 32'h0000_1234; in_empty = 1'b0; hit_ready = 1'b1;
    repeat (2) @(posedge clk160);
    #1;
    check("reset_rd_en", in_rd_en, 1'b0);
    check("reset_valid", hit_valid, 1'b0);
    check("reset_rec", cur_rec(), '0);
    check("reset_counters", {event_count, filler_count, error_count}, '0);
    in_empty = 1'b1;
    reset_n  = 1'b1;

    // Table of single-word steps starting from reset.
    for (int i = 0; i < 21; i++) begin
      apply_word(tbl[i].word);
      check($sformatf("tbl%0d_valid", i), hit_valid, tbl[i].v);
      if (tbl[i].v) check($sformatf("tbl%0d_rec", i), cur_rec(), tbl[i].r);
      check($sformatf("tbl%0d_counters", i), {event_count, filler_count, error_count},
            {tbl[i].evt, tbl[i].fil, tbl[i].err});
    end

    // Orphan TDC and MSB before any LSB header.
    do_reset(1'b0);
    apply_word(32'h0000_0042);
    check("orphan_valid", hit_valid, 1'b1);
    check("orphan_rec", cur_rec(), mkrec(0, 0, 29'h42, 0, 0, 0, 0));
    check("orphan_err", error_count, 16'd1);
    apply_word(32'h8C00_0009);
    check("idle_msb_err", error_count, 16'd2);
    apply_word(32'h8000_0001);
    apply_word(32'h0000_0001);
    check("msb_unchanged_rec", cur_rec(), mkrec(0, 0, 29'h1, 0, 1, 0, 1));
    check("orphan_counters", {event_count, error_count}, {16'd1, 16'd2});

    // Back-pressure: five TDCs queued while the consumer stalls.
    do_reset(1'b0);
    apply_word(32'h8000_0003);
    apply_word(32'h8C00_0002);
    src_q = '{32'hC000_0001, 32'hD000_0002, 32'hE000_0003, 32'hF000_0004, 32'hF000_0005};
    held  = mkrec(0, 1, 29'h1, 2, 3, 0, 1);
    hit_ready = 1'b0;
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) check($sformatf("stall_hold%0d", c), {hit_valid, cur_rec()}, {1'b1, held});
      feed_cycle(p);
      pops += int'(p);
    end
    check("stall_pops", pops, 1);
    hit_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain%0d", k), {hit_valid, hit_tdc}, {1'b1, 29'(k + 1)});
      feed_cycle(p);
    end
    check("drain_end_valid", hit_valid, 1'b0);
    check("drain_err", error_count, 16'd1);

    // noTimestamp format, then reset pulled mid-stream.
    do_reset(1'b1);
    apply_word(32'h0000_0000);
    apply_word(32'h8000_0003);
    check("nots_valid", hit_valid, 1'b1);
    check("nots_rec", cur_rec(), mkrec(2, 0, 29'h1, 0, 0, 0, 0));
    apply_word(32'h0000_0002);
    check("nots_counters", {event_count, filler_count, error_count}, {16'd1, 16'd1, 16'd1});
    hit_ready = 1'b0;
    apply_word(32'h8000_0005);
    check("pre_reset_valid", hit_valid, 1'b1);
    in_empty = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midreset_valid", hit_valid, 1'b0);
    check("midreset_counters", {event_count, filler_count, error_count}, '0);
    check("midreset_rd_en", in_rd_en, 1'b0);

    // Randomized stream with FIFO gaps and random back-pressure.
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) src_q.push_back(rand_word());
    run_stream(1'b1, 20000);

    // Filler counter saturation.
    do_reset(1'b0);
    for (int i = 0; i < 70000; i++) src_q.push_back(32'h0000_9800);
    run_stream(1'b0, 70100);
    check("filler_saturated", filler_count, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
